ram_word: RTL and testbench
===========================

RAM_WORD -- requirements
Module: ram_word

Interface
REQ-001 Parameter AWIDTH, default 8, address width; depth SHALL be 2**AWIDTH words.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 port_a_address  input  AWIDTH  read port A address.
REQ-006 port_a_out  output  WIDTH  read port A data, registered.
REQ-007 port_b_address  input  AWIDTH  read port B address.
REQ-008 port_b_out  output  WIDTH  read port B data, registered.
REQ-009 port_c_address  input  AWIDTH  write port C address.
REQ-010 port_c_data  input  WIDTH  write port C data.
REQ-011 port_c_we  input  1  write enable for port C, active high.

Function
REQ-012 Storage SHALL be a 2**AWIDTH x WIDTH array with two independent read ports (A, B) and one write port (C).
REQ-013 At the rising clk edge with port_c_we=1, mem[port_c_address] SHALL take port_c_data; with port_c_we=0, memory SHALL be unchanged.
REQ-014 At each rising clk edge, port_a_out SHALL load mem[port_a_address] and port_b_out SHALL load mem[port_b_address]; read latency is 1 cycle and there is no read enable.
REQ-015 Ports A and B SHALL operate concurrently and independently, including when both address the same word; both outputs then carry identical data.
REQ-016 A read whose address equals port_c_address during a write cycle SHALL follow REQ-027/REQ-028.
REQ-017 All AWIDTH-bit addresses 0 to 2**AWIDTH-1 SHALL be valid; address arithmetic SHALL be performed by the user, and no out-of-range condition exists.
REQ-018 Memory contents after power-up SHALL be undefined, and a read of an unwritten word may return X.
REQ-019 Writes to different addresses in consecutive cycles SHALL all be retained, with no write throughput limit (1 word/cycle).

Reset
REQ-020 While rst_n=0, port_a_out and port_b_out SHALL be 0 immediately, without waiting for a clock edge.
REQ-021 rst_n=0 SHALL block writes, and the memory array SHALL NOT be cleared by reset.
REQ-022 The first rising edge after rst_n deasserts SHALL perform normal reads and writes.
REQ-023 Reset asserted mid-operation SHALL abort only the output registers; a write committed at a prior edge SHALL be retained.

Configuration
REQ-024 Macro RAM_WORD_BYPASS_EN SHALL select read-during-write behaviour at compile time.
REQ-025 Collision is defined as port_c_we=1 with port_c_address equal to a read port's address at the same edge.
REQ-026 The collision rule SHALL apply to each read port independently.
REQ-027 With RAM_WORD_BYPASS_EN defined (write-first), a colliding read port SHALL output port_c_data at that edge.
REQ-028 Without RAM_WORD_BYPASS_EN (read-first), a colliding read port SHALL output the old mem contents, and the new data SHALL be visible on the next read.

Verification
REQ-029 Fill: reset, then for a=1..255,0 write mem[a]=0xFF-a, with we pulsed 1 cycle on / 1 cycle off -> subsequent reads give addr 0x01=0xFE, 0xFF=0x00, 0x00=0xFF.
REQ-030 Sweep A: increment port_a_address by 1 per cycle over 0x00-0xFF -> port_a_out equals 0xFF-addr one cycle later; repeat the sweep on port B with the identical result.
REQ-031 Dual read: A ascending from 0x02 and B descending, plus A=B stepping together -> each port is correct independently, and outputs are equal when addresses match.
REQ-032 Collision: A=C=0x10 with mem=0xEF, write 0x1A -> port_a_out=0x1A with RAM_WORD_BYPASS_EN defined, 0xEF without it; in both cases the next read gives 0x1A and port_b_out at another address is unaffected.
REQ-033 Reset: assert rst_n=0 asynchronously mid-sweep -> both outputs are 0 before the next edge; a write attempted with rst_n=0 leaves the memory unchanged; after release, previously written data reads back intact.

Source files
------------

// File: rtl/ram_word.sv
// ram_word: word RAM with two registered read ports (A, B) and one write port (C).
// Define RAM_WORD_BYPASS_EN for write-first collisions; read-first otherwise.
module ram_word #(
    parameter int AWIDTH = 8,
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] port_a_address,
    output logic [WIDTH-1:0]  port_a_out,
    input  logic [AWIDTH-1:0] port_b_address,
    output logic [WIDTH-1:0]  port_b_out,
    input  logic [AWIDTH-1:0] port_c_address,
    input  logic [WIDTH-1:0]  port_c_data,
    input  logic              port_c_we
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] port_a_d, port_a_q;
    logic [WIDTH-1:0] port_b_d, port_b_q;
    logic             wr_en;

    // Writes are held off while reset is asserted; the array itself is never cleared.
    assign wr_en = port_c_we && rst_n;

    always_comb begin
`ifdef RAM_WORD_BYPASS_EN
        port_a_d = (port_c_we && port_c_address == port_a_address) ? port_c_data : mem_q[port_a_address];
        port_b_d = (port_c_we && port_c_address == port_b_address) ? port_c_data : mem_q[port_b_address];
`else
        port_a_d = mem_q[port_a_address];
        port_b_d = mem_q[port_b_address];
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[port_c_address] <= port_c_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_a_q <= '0;
            port_b_q <= '0;
        end else begin
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
        end
    end

    assign port_a_out = port_a_q;
    assign port_b_out = port_b_q;
endmodule

// File: tb/tb_ram_word.sv
// tb_ram_word: directed scoreboard bench for ram_word (fill, sweeps, dual read, collision, reset).
module tb_ram_word;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] port_a_address = '0;
    logic [7:0] port_b_address = '0;
    logic [7:0] port_c_address = '0;
    logic [7:0] port_c_data = '0;
    logic       port_c_we = 1'b0;
    logic [7:0] port_a_out, port_b_out;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         ca;
        bit         cb;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [256];
    int         errors = 0;
    int         checks = 0;

    ram_word #(.AWIDTH(8), .WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .port_a_address(port_a_address),
        .port_a_out(port_a_out),
        .port_b_address(port_b_address),
        .port_b_out(port_b_out),
        .port_c_address(port_c_address),
        .port_c_data(port_c_data),
        .port_c_we(port_c_we)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit ca, input logic [7:0] ea, input bit cb, input logic [7:0] eb);
        exp_t e;
        e.a = ea; e.b = eb; e.ca = ca; e.cb = cb;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.ca) begin
                checks++;
                assert (port_a_out === e.a) else begin
                    errors++;
                    $error("FAIL %s port_a observed=%h expected=%h", tag, port_a_out, e.a);
                end
            end
            if (e.cb) begin
                checks++;
                assert (port_b_out === e.b) else begin
                    errors++;
                    $error("FAIL %s port_b observed=%h expected=%h", tag, port_b_out, e.b);
                end
            end
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] exp_col;
        // Asynchronous reset clears outputs with no clock edge
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        assert (port_a_out === 8'h00) else begin errors++; $error("FAIL rst_a observed=%h expected=00", port_a_out); end
        assert (port_b_out === 8'h00) else begin errors++; $error("FAIL rst_b observed=%h expected=00", port_b_out); end
        cycle();
        checks += 2;
        assert (port_a_out === 8'h00) else begin errors++; $error("FAIL rst_hold_a observed=%h expected=00", port_a_out); end
        assert (port_b_out === 8'h00) else begin errors++; $error("FAIL rst_hold_b observed=%h expected=00", port_b_out); end
        rst_n = 1'b1;

        // Fill a=1..255,0 with 0xFF-a, we pulsed one cycle on, one off
        for (int i = 1; i <= 256; i++) begin
            a = 8'(i);
            port_c_address = a;
            port_c_data = 8'hFF - a;
            port_c_we = 1'b1;
            cycle();
            mdl[a] = 8'hFF - a;
            port_c_we = 1'b0;
            cycle();
        end

        // Sweep A then B
        for (int i = 0; i < 256; i++) begin
            port_a_address = 8'(i);
            push(1, 8'hFF - 8'(i), 0, 8'h00);
            cycle();
            check_out("sweep_a");
        end
        for (int i = 0; i < 256; i++) begin
            port_b_address = 8'(i);
            push(0, 8'h00, 1, 8'hFF - 8'(i));
            cycle();
            check_out("sweep_b");
        end

        // Dual read: A ascending from 0x02, B descending; then A=B together
        for (int i = 0; i < 32; i++) begin
            port_a_address = 8'h02 + 8'(i);
            port_b_address = 8'hFF - 8'(i);
            push(1, mdl[8'h02 + 8'(i)], 1, mdl[8'hFF - 8'(i)]);
            cycle();
            check_out("dual_opp");
        end
        for (int i = 0; i < 16; i++) begin
            port_a_address = 8'(i * 17);
            port_b_address = 8'(i * 17);
            push(1, mdl[8'(i * 17)], 1, mdl[8'(i * 17)]);
            cycle();
            check_out("dual_same");
            checks++;
            assert (port_a_out === port_b_out) else begin
                errors++;
                $error("FAIL dual_eq port_a=%h port_b=%h", port_a_out, port_b_out);
            end
        end

        // Collision: A=C=0x10 (mem=0xEF) writing 0x1A, B elsewhere
`ifdef RAM_WORD_BYPASS_EN
        exp_col = 8'h1A;
`else
        exp_col = 8'hEF;
`endif
        port_a_address = 8'h10;
        port_b_address = 8'h20;
        port_c_address = 8'h10;
        port_c_data = 8'h1A;
        port_c_we = 1'b1;
        push(1, exp_col, 1, mdl[8'h20]);
        cycle();
        check_out("collide");
        mdl[8'h10] = 8'h1A;
        port_c_we = 1'b0;
        push(1, 8'h1A, 1, mdl[8'h20]);
        cycle();
        check_out("collide_next");

        // Reset mid-sweep: outputs drop before the next edge, writes blocked
        port_a_address = 8'h30;
        port_b_address = 8'h31;
        push(1, mdl[8'h30], 1, mdl[8'h31]);
        cycle();
        check_out("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        assert (port_a_out === 8'h00) else begin errors++; $error("FAIL mid_rst_a observed=%h expected=00", port_a_out); end
        assert (port_b_out === 8'h00) else begin errors++; $error("FAIL mid_rst_b observed=%h expected=00", port_b_out); end
        port_c_address = 8'h40;
        port_c_data = 8'h55;
        port_c_we = 1'b1;
        cycle();
        port_c_we = 1'b0;
        #2 rst_n = 1'b1;
        // First edge after release: read 0x40 and write 0x41 together
        port_a_address = 8'h40;
        port_b_address = 8'h10;
        port_c_address = 8'h41;
        port_c_data = 8'h77;
        port_c_we = 1'b1;
        push(1, mdl[8'h40], 1, mdl[8'h10]);
        cycle();
        check_out("post_rst");
        mdl[8'h41] = 8'h77;
        port_c_we = 1'b0;
        port_a_address = 8'h41;
        port_b_address = 8'h00;
        push(1, mdl[8'h41], 1, mdl[8'h00]);
        cycle();
        check_out("post_rst_wr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
